reg_bank_ctrl: RTL and testbench



---
 rtl/reg_bank_pkg.sv | 19 +
 rtl/reg_bank_w1c_cell.sv | 28 ++
 rtl/reg_bank_ctrl.sv | 113 +++++++++++
 tb/tb_reg_bank_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared access types and address decode for the register bank.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    ACC_RW   = 2'd0,
    ACC_W1C  = 2'd1,
    ACC_NONE = 2'd2
  } acc_e;

  // Map an address onto its access type given the RW and status counts.
  function automatic acc_e decode_acc(input int unsigned addr,
                                      input int unsigned num_rw,
                                      input int unsigned num_sts);
    if (addr < num_rw) return ACC_RW;
    if (addr < num_rw + num_sts) return ACC_W1C;
    return ACC_NONE;
  endfunction

endpackage

// File: rtl/reg_bank_w1c_cell.sv
// One write-1-to-clear status register; a hardware set beats a same-cycle clear.
module reg_bank_w1c_cell #(
  parameter int unsigned DATA_W = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] set_i,
  input  logic [DATA_W-1:0] clr_i,
  output logic [DATA_W-1:0] sts_o
);

  logic [DATA_W-1:0] sts_q;
  logic [DATA_W-1:0] sts_d;

  // Clear first, then OR in the set pulses so set wins.
  always_comb begin
    sts_d = (sts_q & ~clr_i) | set_i;
  end

  // Status flop; reset also masks any HW set arriving during reset.
  always_ff @(posedge CLK) begin
    if (RST) sts_q <= '0;
    else     sts_q <= sts_d;
  end

  assign sts_o = sts_q;

endmodule

// File: rtl/reg_bank_ctrl.sv
// Parametrised register bank: RW config regs, W1C status regs, registered
// reads with a valid pulse, and a saturating unmapped-access counter.
module reg_bank_ctrl
  import reg_bank_pkg::*;
#(
  parameter int unsigned       DATA_W  = 2,
  parameter int unsigned       ADDR_W  = 3,
  parameter int unsigned       NUM_RW  = 4,
  parameter int unsigned       NUM_STS = 2,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int unsigned       ERR_W   = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      WRITE,
  input  logic                      READ,
  input  logic [ADDR_W-1:0]         ADDR,
  input  logic [DATA_W-1:0]         WRITE_DATA,
  output logic [DATA_W-1:0]         READ_DATA,
  output logic                      READ_VALID,
  output logic [NUM_RW*DATA_W-1:0]  CFG_OUT,
  input  logic [NUM_STS*DATA_W-1:0] HW_SET,
  output logic [NUM_STS*DATA_W-1:0] STS_OUT,
  output logic                      ACC_ERR,
  output logic [ERR_W-1:0]          ERR_CNT
);

  localparam int unsigned      CFG_W   = NUM_RW * DATA_W;
  localparam int unsigned      STS_W   = NUM_STS * DATA_W;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [STS_W-1:0]  sts_clr, sts_val;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              acc_err_q, acc_err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  int unsigned       addr_u;
  acc_e              acc;

  assign addr_u = 32'(ADDR);
  assign acc    = decode_acc(addr_u, NUM_RW, NUM_STS);

  // RW register write path.
  always_comb begin
    cfg_d = cfg_q;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (WRITE && (acc == ACC_RW) && (addr_u == i)) cfg_d[i*DATA_W +: DATA_W] = WRITE_DATA;
    end
  end

  // Per-status-register clear mask from a W1C write.
  always_comb begin
    sts_clr = '0;
    for (int unsigned j = 0; j < NUM_STS; j++) begin
      if (WRITE && (acc == ACC_W1C) && (addr_u == NUM_RW + j)) sts_clr[j*DATA_W +: DATA_W] = WRITE_DATA;
    end
  end

  for (genvar g = 0; g < NUM_STS; g++) begin : g_sts
    reg_bank_w1c_cell #(.DATA_W(DATA_W)) u_cell (
      .CLK   (CLK),
      .RST   (RST),
      .set_i (HW_SET[g*DATA_W +: DATA_W]),
      .clr_i (sts_clr[g*DATA_W +: DATA_W]),
      .sts_o (sts_val[g*DATA_W +: DATA_W])
    );
  end

  // Read mux on pre-edge contents, plus access-error pulse and counter.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = READ;
    acc_err_d  = 1'b0;
    err_cnt_d  = err_cnt_q;
    if (READ) begin
      rd_data_d = '0;
      for (int unsigned i = 0; i < NUM_RW; i++) begin
        if ((acc == ACC_RW) && (addr_u == i)) rd_data_d = cfg_q[i*DATA_W +: DATA_W];
      end
      for (int unsigned j = 0; j < NUM_STS; j++) begin
        if ((acc == ACC_W1C) && (addr_u == NUM_RW + j)) rd_data_d = sts_val[j*DATA_W +: DATA_W];
      end
    end
    if ((WRITE || READ) && (acc == ACC_NONE)) acc_err_d = 1'b1;
    if (acc_err_d && (err_cnt_q != ERR_MAX)) err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cfg_q      <= {NUM_RW{RST_VAL}};
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      acc_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      cfg_q      <= cfg_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      acc_err_q  <= acc_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign CFG_OUT    = cfg_q;
  assign STS_OUT    = sts_val;
  assign READ_DATA  = rd_data_q;
  assign READ_VALID = rd_valid_q;
  assign ACC_ERR    = acc_err_q;
  assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed bench for reg_bank_ctrl with a read-data scoreboard queue.
module tb_reg_bank_ctrl;

  logic       CLK;
  logic       RST;
  logic       WRITE;
  logic       READ;
  logic [2:0] ADDR;
  logic [1:0] WRITE_DATA;
  logic [1:0] READ_DATA;
  logic       READ_VALID;
  logic [7:0] CFG_OUT;
  logic [3:0] HW_SET;
  logic [3:0] STS_OUT;
  logic       ACC_ERR;
  logic [3:0] ERR_CNT;

  reg_bank_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .WRITE      (WRITE),
    .READ       (READ),
    .ADDR       (ADDR),
    .WRITE_DATA (WRITE_DATA),
    .READ_DATA  (READ_DATA),
    .READ_VALID (READ_VALID),
    .CFG_OUT    (CFG_OUT),
    .HW_SET     (HW_SET),
    .STS_OUT    (STS_OUT),
    .ACC_ERR    (ACC_ERR),
    .ERR_CNT    (ERR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [1:0] cfg_m [4];
  logic [1:0] sts_m [2];
  logic [1:0] rd_hold_m;
  int         err_m;
  logic       acc_err_m;
  logic       rv_m;
  logic [1:0] rd_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model, then check every output after the edge.
  task automatic cyc(input logic rst, input logic wr, input logic rd,
                     input logic [2:0] addr, input logic [1:0] wd, input logic [3:0] hw);
    logic [1:0] rv_data;
    int a;
    RST = rst; WRITE = wr; READ = rd; ADDR = addr; WRITE_DATA = wd; HW_SET = hw;
    a = int'(addr);
    if (rst) begin
      for (int i = 0; i < 4; i++) cfg_m[i] = 2'b00;
      sts_m[0] = 2'b00; sts_m[1] = 2'b00;
      err_m = 0; acc_err_m = 1'b0; rv_m = 1'b0; rd_hold_m = 2'b00;
      rd_q.delete();
    end else begin
      rv_m = rd;
      if (rd) begin
        if (a < 4)      rd_q.push_back(cfg_m[a]);
        else if (a < 6) rd_q.push_back(sts_m[a-4]);
        else            rd_q.push_back(2'b00);
      end
      acc_err_m = (wr || rd) && (a >= 6);
      if (acc_err_m && err_m < 15) err_m++;
      if (wr && a < 4) cfg_m[a] = wd;
      if (wr && a >= 4 && a < 6) sts_m[a-4] = sts_m[a-4] & ~wd;
      sts_m[0] = sts_m[0] | hw[1:0];
      sts_m[1] = sts_m[1] | hw[3:2];
    end
    @(posedge CLK);
    #1;
    check("read_valid", 32'(READ_VALID), 32'(rv_m));
    if (rv_m) begin
      if (rd_q.size() == 0) begin
        check("scoreboard_underflow", 32'(1), 32'(0));
      end else begin
        rv_data = rd_q.pop_front();
        rd_hold_m = rv_data;
      end
    end
    check("read_data", 32'(READ_DATA), 32'(rd_hold_m));
    check("acc_err", 32'(ACC_ERR), 32'(acc_err_m));
    check("err_cnt", 32'(ERR_CNT), 32'(err_m));
    check("cfg_out", 32'(CFG_OUT), 32'({cfg_m[3], cfg_m[2], cfg_m[1], cfg_m[0]}));
    check("sts_out", 32'(STS_OUT), 32'({sts_m[1], sts_m[0]}));
  endtask

  initial begin
    RST = 1'b1; WRITE = 1'b0; READ = 1'b0; ADDR = '0; WRITE_DATA = '0; HW_SET = '0;
    err_m = 0; rd_hold_m = '0; acc_err_m = 1'b0; rv_m = 1'b0;

    // Reset
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 4'h0);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 4'h0);

    // Read every mapped address after reset
    for (int a = 0; a < 6; a++) cyc(1'b0, 1'b0, 1'b1, 3'(a), 2'b00, 4'h0);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 4'h0);

    // RW write then read back
    cyc(1'b0, 1'b1, 1'b0, 3'd2, 2'b10, 4'h0);
    cyc(1'b0, 1'b0, 1'b1, 3'd2, 2'b00, 4'h0);
    check("rd_addr2", 32'(READ_DATA), 32'(2'b10));
    check("cfg2_slice", 32'(CFG_OUT[5:4]), 32'(2'b10));
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 2'b11, 4'h0);
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 2'b01, 4'h0);

    // HW set, set-beats-clear, then a clean W1C clear
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 4'b0001);
    check("sts0_set", 32'(STS_OUT[1:0]), 32'(2'b01));
    cyc(1'b0, 1'b1, 1'b0, 3'd4, 2'b01, 4'b0001);
    check("sts0_set_wins", 32'(STS_OUT[1:0]), 32'(2'b01));
    cyc(1'b0, 1'b1, 1'b0, 3'd4, 2'b01, 4'h0);
    check("sts0_cleared", 32'(STS_OUT[1:0]), 32'(2'b00));
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 4'b1100);
    cyc(1'b0, 1'b1, 1'b1, 3'd5, 2'b01, 4'h0);
    check("sts1_rbw", 32'(READ_DATA), 32'(2'b11));
    cyc(1'b0, 1'b0, 1'b1, 3'd5, 2'b00, 4'h0);
    check("sts1_partial_clr", 32'(READ_DATA), 32'(2'b10));

    // Unmapped accesses until the counter saturates
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 3'd6, 2'b00, 4'h0);
      cyc(1'b0, 1'b1, 1'b0, 3'd7, 2'b11, 4'h0);
    end
    check("err_sat", 32'(ERR_CNT), 32'(15));
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 4'h0);
    check("acc_err_idle", 32'(ACC_ERR), 32'(0));

    // Same-cycle write and read to one RW address
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 2'b01, 4'h0);
    cyc(1'b0, 1'b1, 1'b1, 3'd1, 2'b11, 4'h0);
    check("rbw_old", 32'(READ_DATA), 32'(2'b01));
    cyc(1'b0, 1'b0, 1'b1, 3'd1, 2'b00, 4'h0);
    check("rbw_new", 32'(READ_DATA), 32'(2'b11));

    // Reset with a read pending, HW set ignored during reset
    cyc(1'b1, 1'b0, 1'b1, 3'd0, 2'b00, 4'hF);
    check("rst_no_valid", 32'(READ_VALID), 32'(0));
    check("rst_cfg", 32'(CFG_OUT), 32'(0));
    check("rst_sts", 32'(STS_OUT), 32'(0));
    check("rst_err", 32'(ERR_CNT), 32'(0));

    // Simultaneous unmapped write and read count once
    cyc(1'b0, 1'b1, 1'b1, 3'd7, 2'b01, 4'h0);
    check("dual_unmapped_cnt", 32'(ERR_CNT), 32'(1));
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
